// File: rtl/rom_port_arbiter_pkg.sv
// rom_port_arbiter_pkg
// Shared definitions for the ROM port arbiter: FSM state encoding, owner
// constants, the memory-latency ceiling and a constant clog2 helper.
package rom_port_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    localparam logic OWNER_IF = 1'b0;
    localparam logic OWNER_D  = 1'b1;

    // Latency counter is sized for the largest supported ROM latency.
    localparam int MEM_LATENCY_MAX = 15;
    localparam int CNT_W           = 4;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter
// Shares one single-port, synchronous-read 32-bit ROM between instruction
// fetch (IF) and data load (D). Each access runs IDLE -> ISSUE -> WAIT -> RESP;
// out-of-range addresses short-cut IDLE -> RESP with err=1 and never strobe
// the ROM. Simultaneous requests are granted round-robin.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   if_req/if_addr                fetch request (level) and byte address
//   if_rvalid/if_rdata/if_err     fetch response pulse, data, range error
//   d_req/d_addr                  load request (level) and byte address
//   d_rvalid/d_rdata/d_err        load response pulse, data, range error
//   mem_en/mem_addr/mem_rdata     ROM read strobe, word address, read data
//   busy                          high whenever the FSM is not IDLE
module rom_port_arbiter
    import rom_port_arbiter_pkg::*;
#(
    parameter int  WORDS       = 4096,
    parameter int  MEM_LATENCY = 1,
    localparam int AW          = clog2(WORDS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [31:0]   if_addr,
    output logic          if_rvalid,
    output logic [31:0]   if_rdata,
    output logic          if_err,
    input  logic          d_req,
    input  logic [31:0]   d_addr,
    output logic          d_rvalid,
    output logic [31:0]   d_rdata,
    output logic          d_err,
    output logic          mem_en,
    output logic [AW-1:0] mem_addr,
    input  logic [31:0]   mem_rdata,
    output logic          busy
);

    // Out-of-range latency parameters are clamped into the counter's range.
    localparam int LAT = (MEM_LATENCY < 1) ? 1 :
                         (MEM_LATENCY > MEM_LATENCY_MAX) ? MEM_LATENCY_MAX : MEM_LATENCY;

    state_e           state_q;
    logic             owner_q;
    logic             last_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      rdata_q;
    logic             err_q;
    logic [AW-1:0]    mem_addr_q;

    // Word view of each address; the two byte-offset bits are dropped.
    logic [31:0]   if_word, d_word;
    logic          if_oor, d_oor;
    logic          grant_d;
    logic          gnt_oor_d;
    logic [AW-1:0] gnt_idx_d;

    assign if_word = if_addr >> 2;
    assign d_word  = d_addr >> 2;
    assign if_oor  = (if_word >> AW) != 32'd0;
    assign d_oor   = (d_word >> AW) != 32'd0;

    // Round-robin: on a tie the requester not granted last time wins.
    always_comb begin
        grant_d = OWNER_IF;
        if (if_req && d_req)
            grant_d = (last_q == OWNER_D) ? OWNER_IF : OWNER_D;
        else if (d_req)
            grant_d = OWNER_D;
    end

    assign gnt_oor_d = (grant_d == OWNER_D) ? d_oor : if_oor;
    assign gnt_idx_d = (grant_d == OWNER_D) ? d_word[AW-1:0] : if_word[AW-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            owner_q    <= OWNER_IF;
            last_q     <= OWNER_D;
            cnt_q      <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (if_req || d_req) begin
                        owner_q <= grant_d;
                        last_q  <= grant_d;
                        if (gnt_oor_d) begin
                            // Range error: answer next cycle, ROM untouched.
                            err_q   <= 1'b1;
                            rdata_q <= '0;
                            state_q <= S_RESP;
                        end else begin
                            err_q      <= 1'b0;
                            mem_addr_q <= gnt_idx_d;
                            state_q    <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    cnt_q   <= CNT_W'(LAT);
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    // cnt==1 is the cycle the ROM data is valid on mem_rdata.
                    if (cnt_q == CNT_W'(1)) begin
                        rdata_q <= mem_rdata;
                        state_q <= S_RESP;
                    end
                end
                S_RESP:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign mem_en    = (state_q == S_ISSUE);
    assign mem_addr  = mem_addr_q;
    assign if_rvalid = (state_q == S_RESP) && (owner_q == OWNER_IF);
    assign d_rvalid  = (state_q == S_RESP) && (owner_q == OWNER_D);
    assign if_rdata  = rdata_q;
    assign d_rdata   = rdata_q;
    assign if_err    = err_q;
    assign d_err     = err_q;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Bench for rom_port_arbiter. Two instances: k=0 at MEM_LATENCY=1 and k=1 at
// MEM_LATENCY=3, each with a behavioural ROM that only drives valid data in
// the exact cycle the access latency promises (garbage otherwise).
module tb_rom_port_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req    [2];
    logic [31:0] if_addr   [2];
    logic        if_rvalid [2];
    logic [31:0] if_rdata  [2];
    logic        if_err    [2];
    logic        d_req     [2];
    logic [31:0] d_addr    [2];
    logic        d_rvalid  [2];
    logic [31:0] d_rdata   [2];
    logic        d_err     [2];
    logic        mem_en    [2];
    logic [11:0] mem_addr  [2];
    logic [31:0] mem_rdata [2];
    logic        busy      [2];

    int passed = 0;
    int total  = 0;
    int fails  = 0;
    bit last_d [2];   // model: last grant went to D

    rom_port_arbiter #(.WORDS(4096), .MEM_LATENCY(1)) u0 (
        .clk(clk), .rst(rst),
        .if_req(if_req[0]), .if_addr(if_addr[0]), .if_rvalid(if_rvalid[0]),
        .if_rdata(if_rdata[0]), .if_err(if_err[0]),
        .d_req(d_req[0]), .d_addr(d_addr[0]), .d_rvalid(d_rvalid[0]),
        .d_rdata(d_rdata[0]), .d_err(d_err[0]),
        .mem_en(mem_en[0]), .mem_addr(mem_addr[0]), .mem_rdata(mem_rdata[0]),
        .busy(busy[0])
    );

    rom_port_arbiter #(.WORDS(4096), .MEM_LATENCY(3)) u1 (
        .clk(clk), .rst(rst),
        .if_req(if_req[1]), .if_addr(if_addr[1]), .if_rvalid(if_rvalid[1]),
        .if_rdata(if_rdata[1]), .if_err(if_err[1]),
        .d_req(d_req[1]), .d_addr(d_addr[1]), .d_rvalid(d_rvalid[1]),
        .d_rdata(d_rdata[1]), .d_err(d_err[1]),
        .mem_en(mem_en[1]), .mem_addr(mem_addr[1]), .mem_rdata(mem_rdata[1]),
        .busy(busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [11:0] idx);
        if (idx == 12'd4) return 32'h0000_0013;
        return ({20'h0, idx} * 32'h9E37_79B1) ^ 32'hA5A5_0000;
    endfunction

    // Behavioural ROMs: data appears MEM_LATENCY cycles after the mem_en cycle.
    logic [31:0] p0, q0, q1, q2;
    always @(posedge clk) begin
        p0 <= mem_en[0] ? rom_word(mem_addr[0]) : 32'hDEAD_BEEF;
        q0 <= mem_en[1] ? rom_word(mem_addr[1]) : 32'hDEAD_BEEF;
        q1 <= q0;
        q2 <= q1;
    end
    assign mem_rdata[0] = p0;
    assign mem_rdata[1] = q2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rnd_addr();
        logic [31:0] a;
        a = $urandom;
        if ($urandom_range(0, 3) != 0) a = a & 32'h0000_3FFF;
        else a = a | (32'h1 << $urandom_range(14, 31));
        return a;
    endfunction

    task automatic chk_quiet(input int k, input string tag);
        chk({tag, "/busy"},  busy[k],      0);
        chk({tag, "/men"},   mem_en[k],    0);
        chk({tag, "/ifv"},   if_rvalid[k], 0);
        chk({tag, "/dv"},    d_rvalid[k],  0);
        chk({tag, "/ifd"},   if_rdata[k],  0);
        chk({tag, "/ife"},   if_err[k],    0);
        chk({tag, "/maddr"}, mem_addr[k],  0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            if_req[k] = 1'b0; d_req[k] = 1'b0; if_addr[k] = '0; d_addr[k] = '0;
        end
        repeat (2) @(negedge clk);
        chk_quiet(0, "rst0");
        chk_quiet(1, "rst1");
        rst = 1'b0;
        last_d[0] = 1'b1;
        last_d[1] = 1'b1;
    endtask

    // Transaction-level model: builds the expected grant schedule for nif
    // fetches and nd loads (requests held until served), then checks every
    // cycle. Negedge n=0 is the IDLE cycle in which the requests first show.
    task automatic run(input int k, input int nif, input int nd,
                       input logic [31:0] ia, input logic [31:0] da, input string tag);
        bit          who [16];
        bit          oor [16];
        int          st  [16];
        int          rs  [16];
        logic [31:0] ad  [16];
        int ns, ri, rdn, t, lat, drop_if, drop_d, endn, cif, cd;
        bit g;
        logic eif, ed, eb, een;
        logic [11:0] ea;
        string tg;
        ns = 0; ri = nif; rdn = nd; t = 0; lat = (k == 0) ? 1 : 3;
        drop_if = -1; drop_d = -1; cif = 0; cd = 0;
        while ((ri > 0 || rdn > 0) && ns < 16) begin
            if (ri > 0 && rdn > 0) g = !last_d[k];
            else g = (rdn > 0);
            last_d[k] = g;
            if (g) rdn--; else ri--;
            who[ns] = g;
            ad[ns]  = g ? da : ia;
            oor[ns] = (ad[ns] >> 14) != 0;
            st[ns]  = t;
            rs[ns]  = t + (oor[ns] ? 1 : lat + 2);
            if (g) drop_d = rs[ns]; else drop_if = rs[ns];
            t = rs[ns] + 1;   // next grant is sampled in the IDLE after RESP
            ns++;
        end
        endn = t;
        if_addr[k] = ia; d_addr[k] = da;
        if_req[k] = (nif > 0); d_req[k] = (nd > 0);
        for (int n = 1; n <= endn; n++) begin
            @(negedge clk);
            eif = 0; ed = 0; eb = 0; een = 0; ea = '0;
            for (int s = 0; s < ns; s++) begin
                if (n == rs[s]) begin
                    if (who[s]) ed = 1; else eif = 1;
                end
                if (n > st[s] && n <= rs[s]) eb = 1;
                if (!oor[s] && n == st[s] + 1) begin
                    een = 1;
                    ea  = ad[s][13:2];
                end
            end
            tg = $sformatf("%s/k%0d/c%0d", tag, k, n);
            chk({tg, "/busy"}, busy[k],      eb);
            chk({tg, "/men"},  mem_en[k],    een);
            chk({tg, "/ifv"},  if_rvalid[k], eif);
            chk({tg, "/dv"},   d_rvalid[k],  ed);
            if (een) chk({tg, "/maddr"}, mem_addr[k], ea);
            for (int s = 0; s < ns; s++) begin
                if (n == rs[s]) begin
                    if (who[s]) begin
                        chk({tg, "/drd"}, d_rdata[k], oor[s] ? 32'h0 : rom_word(ad[s][13:2]));
                        chk({tg, "/derr"}, d_err[k], oor[s]);
                    end else begin
                        chk({tg, "/ifrd"}, if_rdata[k], oor[s] ? 32'h0 : rom_word(ad[s][13:2]));
                        chk({tg, "/iferr"}, if_err[k], oor[s]);
                    end
                end
            end
            if (if_rvalid[k]) cif++;
            if (d_rvalid[k])  cd++;
            if (n == drop_if) if_req[k] = 1'b0;
            if (n == drop_d)  d_req[k]  = 1'b0;
        end
        chk({tag, "/nif"}, cif, nif);
        chk({tag, "/nd"},  cd,  nd);
    endtask

    int rk, rsel, rni, rnd;

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            if_req[k] = 1'b0; d_req[k] = 1'b0; if_addr[k] = '0; d_addr[k] = '0;
        end
        do_reset();

        // Tie right after reset: IF first (word 2), then D (word 3).
        run(0, 1, 1, 32'h0000_0008, 32'h0000_000C, "tie");
        // Single fetch of word 4.
        run(0, 1, 0, 32'h0000_0010, 32'h0, "ifsingle");
        // Both held for 8 transactions: strict alternation.
        run(0, 4, 4, 32'h0000_0100, 32'h0000_0207, "fair");
        // Out of range load: one-cycle error response, no ROM strobe.
        run(0, 0, 1, 32'h0, 32'h0000_4000, "oor");
        // Last in-range word with junk byte-offset bits.
        run(0, 1, 0, 32'h0000_3FFF, 32'h0, "lastword");

        // Reset during WAIT: access abandoned, outputs cleared.
        @(negedge clk);
        if_addr[0] = 32'h0000_0024;
        if_req[0]  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("midrst/inwait", busy[0], 1);
        rst = 1'b1;
        if_req[0] = 1'b0;
        @(negedge clk);
        chk_quiet(0, "midrst/after");
        chk("midrst/drd", d_rdata[0], 0);
        chk("midrst/derr", d_err[0], 0);
        rst = 1'b0;
        last_d[0] = 1'b1;
        last_d[1] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midrst/noifv", if_rvalid[0], 0);
            chk("midrst/nodv",  d_rvalid[0],  0);
        end
        run(0, 1, 0, 32'h0000_0024, 32'h0, "postrst");

        // MEM_LATENCY=3 instance.
        run(1, 0, 1, 32'h0, 32'h0000_0004, "lat3");
        run(1, 2, 2, 32'h0000_0010, 32'h0000_5000, "lat3mix");

        // Randomized transactions on both instances.
        for (int i = 0; i < 30; i++) begin
            rk   = $urandom_range(0, 1);
            rsel = $urandom_range(1, 3);
            rni  = (rsel & 1) != 0 ? $urandom_range(1, 2) : 0;
            rnd  = (rsel & 2) != 0 ? $urandom_range(1, 2) : 0;
            run(rk, rni, rnd, rnd_addr(), rnd_addr(), $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
